// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_e;

    localparam logic [2:0] SZ_B = 3'b001;
    localparam logic [2:0] SZ_H = 3'b010;
    localparam logic [2:0] SZ_W = 3'b100;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Unified memory bus between the arbiter (master) and the SoC fabric (slave).
interface mem_port_arbiter_if;

    logic [31:0] M_ADDR;
    logic [31:0] M_WDATA;
    logic [3:0]  M_BE;
    logic        M_RD;
    logic        M_WR;
    logic [31:0] M_RDATA;
    logic        M_RDY;
    logic        M_ERR;

    modport master (
        output M_ADDR, M_WDATA, M_BE, M_RD, M_WR,
        input  M_RDATA, M_RDY, M_ERR
    );

    modport slave (
        input  M_ADDR, M_WDATA, M_BE, M_RD, M_WR,
        output M_RDATA, M_RDY, M_ERR
    );

endinterface

// File: rtl/mem_port_arbiter_lane_fmt.sv
// Byte-enable, store-lane replication and alignment check for a data access.
module mem_lane_fmt
    import mem_arb_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dlen,
    input  logic [31:0] datao,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    always_comb begin
        be       = 4'b0000;
        wdata    = 32'h0;
        misalign = 1'b0;
        case (dlen)
            SZ_B: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{datao[7:0]}};
            end
            SZ_H: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{datao[15:0]}};
                misalign = addr_lo[0];
            end
            SZ_W: begin
                be       = 4'b1111;
                wdata    = datao;
                misalign = |addr_lo;
            end
            // Any other size code is rejected like a misaligned access.
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one memory bus, with
// data-first priority bounded by a starvation counter and a bus timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        I_REQ,
    input  logic [31:0] IADDR,
    output logic [31:0] IDATA,
    output logic        I_ACK,
    input  logic        D_REQ,
    input  logic [31:0] DADDR,
    input  logic [31:0] DATAO,
    input  logic [2:0]  DLEN,
    input  logic        DWR,
    output logic [31:0] DATAI,
    output logic        D_ACK,
    output logic        BERR,
    output logic        HLT,
    mem_port_arbiter_if.master mbus
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    state_e      state_q, state_d;
    gnt_e        gnt_q, gnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_be_q, m_be_d;
    logic        m_rd_q, m_rd_d;
    logic        m_wr_q, m_wr_d;
    logic [31:0] idata_q, idata_d;
    logic [31:0] datai_q, datai_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        berr_q, berr_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        lane_misalign;
    logic        unused_iaddr;

    assign unused_iaddr = ^IADDR[1:0];

    mem_lane_fmt u_lane_fmt (
        .addr_lo  (DADDR[1:0]),
        .dlen     (DLEN),
        .datao    (DATAO),
        .be       (lane_be),
        .wdata    (lane_wdata),
        .misalign (lane_misalign)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        starve_d  = starve_q;
        tmo_d     = tmo_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        m_be_d    = m_be_q;
        m_rd_d    = m_rd_q;
        m_wr_d    = m_wr_q;
        idata_d   = idata_q;
        datai_d   = datai_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        berr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (D_REQ && (starve_q < SW'(STARVE_MAX))) begin
                    gnt_d    = GNT_D;
                    starve_d = I_REQ ? starve_q + 1'b1 : '0;
                    if (lane_misalign) begin
                        // Rejected without touching the bus.
                        state_d = RESP;
                        d_ack_d = 1'b1;
                        berr_d  = 1'b1;
                        datai_d = 32'h0;
                    end else begin
                        state_d   = BUS;
                        tmo_d     = '0;
                        m_addr_d  = {DADDR[31:2], 2'b00};
                        m_be_d    = lane_be;
                        m_wdata_d = lane_wdata;
                        m_rd_d    = ~DWR;
                        m_wr_d    = DWR;
                    end
                end else if (I_REQ) begin
                    gnt_d     = GNT_I;
                    starve_d  = '0;
                    state_d   = BUS;
                    tmo_d     = '0;
                    m_addr_d  = {IADDR[31:2], 2'b00};
                    m_be_d    = 4'b1111;
                    m_wdata_d = 32'h0;
                    m_rd_d    = 1'b1;
                    m_wr_d    = 1'b0;
                end
            end
            BUS: begin
                if (mbus.M_RDY || (tmo_q == TW'(TIMEOUT - 1))) begin
                    state_d = RESP;
                    m_rd_d  = 1'b0;
                    m_wr_d  = 1'b0;
                    berr_d  = mbus.M_RDY ? mbus.M_ERR : 1'b1;
                    if (gnt_q == GNT_I) begin
                        i_ack_d = 1'b1;
                        idata_d = mbus.M_RDY ? mbus.M_RDATA : 32'h0;
                    end else begin
                        d_ack_d = 1'b1;
                        datai_d = mbus.M_RDY ? mbus.M_RDATA : 32'h0;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_I;
            starve_q  <= '0;
            tmo_q     <= '0;
            m_addr_q  <= 32'h0;
            m_wdata_q <= 32'h0;
            m_be_q    <= 4'b0000;
            m_rd_q    <= 1'b0;
            m_wr_q    <= 1'b0;
            idata_q   <= 32'h0;
            datai_q   <= 32'h0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            berr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            starve_q  <= starve_d;
            tmo_q     <= tmo_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            m_be_q    <= m_be_d;
            m_rd_q    <= m_rd_d;
            m_wr_q    <= m_wr_d;
            idata_q   <= idata_d;
            datai_q   <= datai_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            berr_q    <= berr_d;
        end
    end

    assign mbus.M_ADDR  = m_addr_q;
    assign mbus.M_WDATA = m_wdata_q;
    assign mbus.M_BE    = m_be_q;
    assign mbus.M_RD    = m_rd_q;
    assign mbus.M_WR    = m_wr_q;
    assign IDATA        = idata_q;
    assign DATAI        = datai_q;
    assign I_ACK        = i_ack_q;
    assign D_ACK        = d_ack_q;
    assign BERR         = berr_q;

    // Stall is forced low during reset so every output reads 0.
    assign HLT = RES & ((I_REQ & ~i_ack_q) | (D_REQ & ~d_ack_q));

endmodule
